// File: rtl/stream_framer.sv
// stream_framer: wraps every FRAME_LEN stream words between a SYNC header and a checksum word
//   ap_clk, ap_rst                  clock, asynchronous active-high reset
//   in_stream_V_TVALID/TREADY/TDATA upstream 32-bit AXI-stream (accepted only while in DATA)
//   out_stream_V_TVALID/TREADY/TDATA framed 32-bit AXI-stream from a single output register
//   out_stream_V_TLAST              marks the checksum word; present only with STREAM_FRAMER_TLAST_EN
module stream_framer #(
  parameter int unsigned FRAME_LEN = 8,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        in_stream_V_TVALID,
  output logic        in_stream_V_TREADY,
  input  logic [31:0] in_stream_V_TDATA,
  output logic        out_stream_V_TVALID,
  input  logic        out_stream_V_TREADY,
`ifdef STREAM_FRAMER_TLAST_EN
  output logic        out_stream_V_TLAST,
`endif
  output logic [31:0] out_stream_V_TDATA
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  typedef enum logic [1:0] {HDR, DATA, SUM} state_e;
  state_e state_q, state_d;
  logic [7:0] seq_q, seq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] sum_q, sum_d, data_q, data_d;
  logic valid_q, valid_d, load_ok, in_hs;
  assign load_ok = !valid_q || out_stream_V_TREADY;
  assign in_stream_V_TREADY = (state_q == DATA) && load_ok;
  assign in_hs = in_stream_V_TREADY && in_stream_V_TVALID;
  assign out_stream_V_TVALID = valid_q;
  assign out_stream_V_TDATA = data_q;
  always_comb begin
    state_d = state_q;
    seq_d = seq_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    data_d = data_q;
    valid_d = load_ok ? 1'b0 : valid_q;
    case (state_q)
      HDR: if (in_stream_V_TVALID && load_ok) begin
        valid_d = 1'b1;
        data_d = {SYNC, seq_q, FRAME_LEN[15:0]};
        sum_d = '0;
        cnt_d = '0;
        state_d = DATA;
      end
      DATA: if (in_hs) begin
        valid_d = 1'b1;
        data_d = in_stream_V_TDATA;
        sum_d = sum_q + in_stream_V_TDATA;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(FRAME_LEN - 1)) ? SUM : DATA;
      end
      SUM: if (load_ok) begin
        valid_d = 1'b1;
        data_d = sum_q;
        seq_d = seq_q + 8'd1;
        state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= HDR;
      seq_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q <= seq_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
`ifdef STREAM_FRAMER_TLAST_EN
  // every load while in SUM is the checksum word; any other load (or idle) clears it
  logic last_q, last_d;
  assign last_d = load_ok ? (state_q == SUM) : last_q;
  assign out_stream_V_TLAST = last_q;
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) last_q <= 1'b0;
    else last_q <= last_d;
  end
`endif
endmodule

// File: tb/tb_stream_framer.sv
// tb_stream_framer: randomized self-checking bench for stream_framer against a frame-level model
module tb_stream_framer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic in_valid [3];
  logic in_ready [3];
  logic out_valid [3];
  logic out_ready [3];
  logic out_last [3];
  logic [31:0] in_data [3];
  logic [31:0] out_data [3];
  int fl [3] = '{4, 2, 1};
  bit bp [3];
  int checks = 0;
  int failures = 0;
  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];
  logic got_l [$];
  logic exp_l [$];
  logic [7:0] seq_m [3];
  logic pv [3];
  logic pr [3];
  logic pl [3];
  logic [31:0] pdat [3];

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    stream_framer #(.FRAME_LEN(g == 0 ? 4 : g == 1 ? 2 : 1), .SYNC(8'hA5)) dut (
      .ap_clk(clk),
      .ap_rst(rst),
      .in_stream_V_TVALID(in_valid[g]),
      .in_stream_V_TREADY(in_ready[g]),
      .in_stream_V_TDATA(in_data[g]),
      .out_stream_V_TVALID(out_valid[g]),
      .out_stream_V_TREADY(out_ready[g]),
`ifdef STREAM_FRAMER_TLAST_EN
      .out_stream_V_TLAST(out_last[g]),
`endif
      .out_stream_V_TDATA(out_data[g])
    );
`ifndef STREAM_FRAMER_TLAST_EN
    assign out_last[g] = 1'b0;
`endif
  end

  initial begin
    for (int d = 0; d < 3; d++) out_ready[d] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) out_ready[d] = bp[d] ? 1'($urandom % 2) : 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst && pv[d] && !pr[d]) begin
        checks++;
        if (out_valid[d] !== 1'b1 || out_data[d] !== pdat[d] || out_last[d] !== pl[d]) begin
          failures++;
          $display("FAIL stall_hold dut%0d: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   d, out_valid[d], out_data[d], out_last[d], pdat[d], pl[d]);
        end
      end
      if (!rst && out_valid[d] && out_ready[d]) begin
        got_q.push_back(out_data[d]);
        got_l.push_back(out_last[d]);
      end
      pv[d] = out_valid[d];
      pr[d] = out_ready[d];
      pdat[d] = out_data[d];
      pl[d] = out_last[d];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int d, logic [31:0] w);
    bit ok = 1'b0;
    int n = 0;
    in_valid[d] = 1'b1;
    in_data[d] = w;
    while (n < 200 && !ok) begin
      @(negedge clk);
      ok = in_ready[d];
      align();
      n++;
    end
    in_valid[d] = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL push_timeout dut%0d: word %h never accepted, required acceptance within 200 cycles", d, w);
    end
  endtask

  // frame model: header {A5, seq, len}, the words unchanged, then their 32-bit wrapping sum
  task automatic send_frame(int d, logic [31:0] ws [$], int gap_max);
    logic [31:0] s = 0;
    exp_q.push_back({8'hA5, seq_m[d], fl[d][15:0]});
    exp_l.push_back(1'b0);
    foreach (ws[i]) begin
      repeat ($urandom_range(gap_max, 0)) align();
      push(d, ws[i]);
      exp_q.push_back(ws[i]);
      exp_l.push_back(1'b0);
      s += ws[i];
    end
    exp_q.push_back(s);
    exp_l.push_back(1'b1);
    seq_m[d] = seq_m[d] + 8'd1;
  endtask

  task automatic rand_frame(int d, int gap_max);
    logic [31:0] ws [$];
    for (int i = 0; i < fl[d]; i++) ws.push_back($urandom);
    send_frame(d, ws, gap_max);
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    ok = n < 5000;
  endtask

  task automatic clear_q();
    got_q.delete();
    got_l.delete();
    exp_q.delete();
    exp_l.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b1;
      in_data[d] = 32'hDEADBEEF;
      seq_m[d] = 8'd0;
      bp[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (out_valid[d] !== 1'b0 || out_data[d] !== 32'd0 || in_ready[d] !== 1'b0 || out_last[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state dut%0d: valid=%b data=%h tready=%b last=%b, required 0/00000000/0/0",
                 d, out_valid[d], out_data[d], in_ready[d], out_last[d]);
      end
    end
    align();
    for (int d = 0; d < 3; d++) in_valid[d] = 1'b0;
    rst = 1'b0;
    repeat (2) align();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (out_valid[d] !== 1'b0) begin
        failures++;
        $display("FAIL no_early_header dut%0d: valid=%b without input, required 0", d, out_valid[d]);
      end
    end
    clear_q();
  endtask

  task automatic test_basic();
    logic [31:0] ws [$];
    logic [31:0] lit [12];
    logic [5:0] tr;
    bit ok;
    lit = '{32'hA5000004, 1, 2, 3, 4, 32'hA, 32'hA5010004, 5, 6, 7, 8, 32'h1A};
    align();
    ws = '{1, 2, 3, 4};
    fork
      send_frame(0, ws, 0);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        tr[5 - i] = in_ready[0];
      end
    join
    checks++;
    if (tr !== 6'b011110) begin
      failures++;
      $display("FAIL basic_tready: pattern=%b, required 011110", tr);
    end
    ws = '{5, 6, 7, 8};
    send_frame(0, ws, 0);
    drain(ok);
    checks++;
    if (!ok || got_q.size() != 12) begin
      failures++;
      $display("FAIL basic_count: got %0d words, required 12", got_q.size());
    end
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== lit[i]) begin
        failures++;
        $display("FAIL basic_word[%0d]: got %h, required %h", i, got_q[i], lit[i]);
      end
`ifdef STREAM_FRAMER_TLAST_EN
      checks++;
      if (got_l[i] !== (i == 5 || i == 11)) begin
        failures++;
        $display("FAIL basic_tlast[%0d]: got %b, required %b", i, got_l[i], i == 5 || i == 11);
      end
`endif
    end
    clear_q();
  endtask

  task automatic test_overflow();
    logic [31:0] ws [$];
    logic [31:0] lit [4];
    bit ok;
    lit = '{32'hA5000002, 32'hFFFFFFFF, 32'h3, 32'h2};
    align();
    ws = '{32'hFFFFFFFF, 32'h3};
    send_frame(1, ws, 0);
    drain(ok);
    checks++;
    if (!ok || got_q.size() != 4) begin
      failures++;
      $display("FAIL overflow_count: got %0d words, required 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== lit[i]) begin
        failures++;
        $display("FAIL overflow_word[%0d]: got %h, required %h", i, got_q[i], lit[i]);
      end
    end
    clear_q();
    for (int f = 0; f < 6; f++) rand_frame(1, 2);
    drain(ok);
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL len2_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL len2_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_len1_seq_wrap();
    bit ok;
    align();
    for (int f = 0; f < 257; f++) rand_frame(2, 0);
    drain(ok);
    checks++;
    if (!ok || got_q.size() != 771) begin
      failures++;
      $display("FAIL len1_count: got %0d words, required 771", got_q.size());
    end
    if (got_q.size() == 771) begin
      checks++;
      if (got_q[0] !== 32'hA5000001 || got_q[765] !== 32'hA5FF0001 || got_q[768] !== 32'hA5000001) begin
        failures++;
        $display("FAIL seq_wrap: headers %h %h %h, required A5000001 A5FF0001 A5000001",
                 got_q[0], got_q[765], got_q[768]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL len1_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
`ifdef STREAM_FRAMER_TLAST_EN
      checks++;
      if (got_l[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL len1_tlast[%0d]: got %b, required %b", i, got_l[i], exp_l[i]);
      end
`endif
    end
    clear_q();
  endtask

  task automatic test_backpressure();
    bit ok;
    bp[0] = 1'b1;
    align();
    for (int f = 0; f < 100; f++) rand_frame(0, 2);
    drain(ok);
    bp[0] = 1'b0;
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
`ifdef STREAM_FRAMER_TLAST_EN
      checks++;
      if (got_l[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL bp_tlast[%0d]: got %b, required %b", i, got_l[i], exp_l[i]);
      end
`endif
    end
    clear_q();
  endtask

  task automatic test_reset_mid();
    logic [31:0] ws [$];
    logic [31:0] w2;
    bit ok;
    align();
    w2 = $urandom;
    push(0, $urandom);
    push(0, w2);
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== w2) begin
      failures++;
      $display("FAIL mid_pre: valid=%b data=%h, required 1/%h", out_valid[0], out_data[0], w2);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || out_data[0] !== 32'd0) begin
      failures++;
      $display("FAIL mid_async_drop: valid=%b data=%h, required 0/00000000", out_valid[0], out_data[0]);
    end
    repeat (2) align();
    rst = 1'b0;
    clear_q();
    for (int d = 0; d < 3; d++) seq_m[d] = 8'd0;
    align();
    ws = '{$urandom, $urandom, $urandom, $urandom};
    send_frame(0, ws, 1);
    drain(ok);
    checks++;
    if (!ok || got_q.size() != 6) begin
      failures++;
      $display("FAIL mid_count: got %0d words, required 6", got_q.size());
    end
    if (got_q.size() == 6) begin
      checks++;
      if (got_q[0] !== 32'hA5000004 || got_q[5] !== ws[0] + ws[1] + ws[2] + ws[3]) begin
        failures++;
        $display("FAIL mid_frame: header=%h sum=%h, required A5000004/%h",
                 got_q[0], got_q[5], ws[0] + ws[1] + ws[2] + ws[3]);
      end
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_len1_seq_wrap();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
